// File: rtl/ram_arbiter_if.sv
// Bundle of both requester ports and the RAM-side bus of the arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/RAM side.
interface ram_arbiter_if #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 12
);
    logic               a_req_in;
    logic               a_write_in;
    logic [A_WIDTH-1:0] a_address_in;
    logic [D_WIDTH-1:0] a_data_in;
    logic               a_ack_out;
    logic [D_WIDTH-1:0] a_data_out;

    logic               b_req_in;
    logic               b_write_in;
    logic [A_WIDTH-1:0] b_address_in;
    logic [D_WIDTH-1:0] b_data_in;
    logic               b_ack_out;
    logic [D_WIDTH-1:0] b_data_out;

    logic [D_WIDTH-1:0] ram_data_in;
    logic [D_WIDTH-1:0] ram_data_out;
    logic [A_WIDTH-1:0] ram_address_out;
    logic               ram_read_enable_out;
    logic               ram_write_enable_out;
    logic               busy_out;

    modport slave (
        input  a_req_in, a_write_in, a_address_in, a_data_in,
        input  b_req_in, b_write_in, b_address_in, b_data_in,
        input  ram_data_in,
        output a_ack_out, a_data_out, b_ack_out, b_data_out,
        output ram_data_out, ram_address_out, ram_read_enable_out,
        output ram_write_enable_out, busy_out
    );

    modport master (
        output a_req_in, a_write_in, a_address_in, a_data_in,
        output b_req_in, b_write_in, b_address_in, b_data_in,
        output ram_data_in,
        input  a_ack_out, a_data_out, b_ack_out, b_data_out,
        input  ram_data_out, ram_address_out, ram_read_enable_out,
        input  ram_write_enable_out, busy_out
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two req/ack ports sharing a single-port RAM.
// Each transaction follows IDLE -> ISSUE -> CAPTURE. The ack and any read data appear in the following cycle.
module ram_arbiter #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 12
) (
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic [1:0]         r_state;
    logic               r_owner;
    logic               r_last_grant;
    logic               r_write;
    logic [A_WIDTH-1:0] r_address;
    logic [D_WIDTH-1:0] r_data;
    logic               r_a_ack;
    logic               r_b_ack;
    logic [D_WIDTH-1:0] r_a_dout;
    logic [D_WIDTH-1:0] r_b_dout;

    logic w_a_elig;
    logic w_b_elig;
    logic w_grant_a;
    logic w_grant_b;
    logic w_issue;

    // A port acked this cycle still shows req high, so it sits out one round.
    assign w_a_elig  = bus.a_req_in & ~r_a_ack;
    assign w_b_elig  = bus.b_req_in & ~r_b_ack;
    assign w_grant_b = w_b_elig & (~w_a_elig | (r_last_grant == PORT_A));
    assign w_grant_a = w_a_elig & ~w_grant_b;

    // Gating the enables with reset means no RAM access can happen on a reset edge.
    assign w_issue = (r_state == S_ISSUE) & ~reset;

    assign bus.ram_write_enable_out = w_issue &  r_write;
    assign bus.ram_read_enable_out  = w_issue & ~r_write;
    assign bus.ram_address_out      = r_address;
    assign bus.ram_data_out         = r_data;
    assign bus.busy_out             = (r_state != S_IDLE);
    assign bus.a_ack_out            = r_a_ack;
    assign bus.b_ack_out            = r_b_ack;
    assign bus.a_data_out           = r_a_dout;
    assign bus.b_data_out           = r_b_dout;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= PORT_A;
            r_last_grant <= PORT_B;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_data       <= '0;
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_a_dout     <= '0;
            r_b_dout     <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_a) begin
                        r_write      <= bus.a_write_in;
                        r_address    <= bus.a_address_in;
                        r_data       <= bus.a_data_in;
                        r_owner      <= PORT_A;
                        r_last_grant <= PORT_A;
                        r_state      <= S_ISSUE;
                    end else if (w_grant_b) begin
                        r_write      <= bus.b_write_in;
                        r_address    <= bus.b_address_in;
                        r_data       <= bus.b_data_in;
                        r_owner      <= PORT_B;
                        r_last_grant <= PORT_B;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    // The RAM output register now holds the word read in ISSUE.
                    if (r_owner == PORT_A) begin
                        r_a_ack <= 1'b1;
                        if (!r_write) r_a_dout <= bus.ram_data_in;
                    end else begin
                        r_b_ack <= 1'b1;
                        if (!r_write) r_b_dout <= bus.ram_data_in;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter. It drives both ports against a behavioural single-port RAM.
module tb_ram_arbiter;
    localparam int DW = 16;
    localparam int AW = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ram_arbiter_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();
    ram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Single-port RAM: write on posedge, registered read that holds when not reading
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
    logic [DW-1:0] ram_q = '0;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_write_enable_out) mem[bus.ram_address_out] <= bus.ram_data_out;
        if (bus.ram_read_enable_out) ram_q <= mem[bus.ram_address_out];
    end
    assign bus.ram_data_in = ram_q;

    always @(negedge clock) begin
        n_cmp++;
        assert (!(bus.ram_read_enable_out && bus.ram_write_enable_out)) else begin
            n_err++;
            $error("FAIL both_enables: observed re=%0b we=%0b required not both 1",
                   bus.ram_read_enable_out, bus.ram_write_enable_out);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic req, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.a_req_in = req; bus.a_write_in = wr; bus.a_address_in = addr; bus.a_data_in = data;
    endtask

    task automatic drive_b(input logic req, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.b_req_in = req; bus.b_write_in = wr; bus.b_address_in = addr; bus.b_data_in = data;
    endtask

    initial begin
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        pre_we = 1'b1; pre_addr = 12'h200; pre_data = 16'h1234;
        step();
        pre_we = 1'b0;
        step();
        reset = 1'b0;

        // Reset state
        check("rst_a_ack",  bus.a_ack_out, 0);
        check("rst_b_ack",  bus.b_ack_out, 0);
        check("rst_a_data", bus.a_data_out, 0);
        check("rst_b_data", bus.b_data_out, 0);
        check("rst_addr",   bus.ram_address_out, 0);
        check("rst_wdata",  bus.ram_data_out, 0);
        check("rst_re",     bus.ram_read_enable_out, 0);
        check("rst_we",     bus.ram_write_enable_out, 0);
        check("rst_busy",   bus.busy_out, 0);

        // 1: A writes 0x5F5F to 0x001
        drive_a(1'b1, 1'b1, 12'h001, 16'h5F5F);
        step();
        check("s1_c1_we",   bus.ram_write_enable_out, 1);
        check("s1_c1_re",   bus.ram_read_enable_out, 0);
        check("s1_c1_addr", bus.ram_address_out, 12'h001);
        check("s1_c1_dout", bus.ram_data_out, 16'h5F5F);
        check("s1_c1_busy", bus.busy_out, 1);
        step();
        check("s1_c2_we",   bus.ram_write_enable_out, 0);
        check("s1_c2_busy", bus.busy_out, 1);
        check("s1_c2_ack",  bus.a_ack_out, 0);
        check("s1_c2_addr", bus.ram_address_out, 12'h001);
        step();
        check("s1_c3_ack",  bus.a_ack_out, 1);
        check("s1_c3_data", bus.a_data_out, 0);
        check("s1_c3_busy", bus.busy_out, 0);
        bus.a_req_in = 1'b0;
        step();
        check("s1_c4_ack",  bus.a_ack_out, 0);

        // 2: A reads back 0x001
        drive_a(1'b1, 1'b0, 12'h001, 16'h0000);
        step();
        check("s2_c1_re",   bus.ram_read_enable_out, 1);
        check("s2_c1_we",   bus.ram_write_enable_out, 0);
        step();
        step();
        check("s2_c3_ack",  bus.a_ack_out, 1);
        check("s2_c3_data", bus.a_data_out, 16'h5F5F);
        check("s2_c3_bdat", bus.b_data_out, 0);
        bus.a_req_in = 1'b0;
        step();

        // 3: simultaneous first requests after reset; A wins the first tie
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s3_rst_adata", bus.a_data_out, 0);
        drive_a(1'b1, 1'b0, 12'h200, 16'h0000);
        drive_b(1'b1, 1'b0, 12'h001, 16'h0000);
        step();
        check("s3_c1_addr", bus.ram_address_out, 12'h200);
        step();
        step();
        check("s3_c3_aack", bus.a_ack_out, 1);
        check("s3_c3_adat", bus.a_data_out, 16'h1234);
        check("s3_c3_back", bus.b_ack_out, 0);
        bus.a_req_in = 1'b0;
        step();
        check("s3_c4_addr", bus.ram_address_out, 12'h001);
        check("s3_c4_re",   bus.ram_read_enable_out, 1);
        check("s3_c4_aack", bus.a_ack_out, 0);
        step();
        step();
        check("s3_c6_back", bus.b_ack_out, 1);
        check("s3_c6_bdat", bus.b_data_out, 16'h5F5F);
        bus.b_req_in = 1'b0;
        step();

        // 4: both held for four transactions; last grant was B so A goes first
        bus.a_req_in = 1'b1;
        bus.b_req_in = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("s4_c%0d_aack", c), bus.a_ack_out, (c == 3 || c == 9) ? 1 : 0);
            check($sformatf("s4_c%0d_back", c), bus.b_ack_out, (c == 6 || c == 12) ? 1 : 0);
            if (c == 1 || c == 7) check($sformatf("s4_c%0d_addr", c), bus.ram_address_out, 12'h200);
            if (c == 4 || c == 10) check($sformatf("s4_c%0d_addr", c), bus.ram_address_out, 12'h001);
            if (c == 12) begin
                bus.a_req_in = 1'b0;
                bus.b_req_in = 1'b0;
            end
        end
        step();
        check("s4_end_busy", bus.busy_out, 0);

        // 5: reset during ISSUE of a B write aborts it
        drive_b(1'b1, 1'b1, 12'h001, 16'hF5F5);
        step();
        reset = 1'b1;
        bus.b_req_in = 1'b0;
        #1;
        check("s5_issue_we", bus.ram_write_enable_out, 0);
        step();
        reset = 1'b0;
        #1;
        check("s5_busy",  bus.busy_out, 0);
        check("s5_back0", bus.b_ack_out, 0);
        step();
        check("s5_back1", bus.b_ack_out, 0);
        step();
        check("s5_back2", bus.b_ack_out, 0);

        // 6: address change after the grant does not affect the read in flight
        drive_a(1'b1, 1'b0, 12'h001, 16'h0000);
        step();
        bus.a_address_in = 12'h000;
        #1;
        check("s6_c1_addr", bus.ram_address_out, 12'h001);
        check("s6_c1_re",   bus.ram_read_enable_out, 1);
        step();
        check("s6_c2_addr", bus.ram_address_out, 12'h001);
        step();
        check("s6_c3_ack",  bus.a_ack_out, 1);
        check("s6_c3_data", bus.a_data_out, 16'h5F5F);
        bus.a_req_in = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port main RAM (D_WIDTH data, A_WIDTH address, registered read output that holds when not reading, write on posedge).
- Shares the RAM between the CPU memory port (port A) and the I/O / DMA port (port B) using round-robin priority and a req/ack handshake.
- Drives the RAM read/write enables, address and data, and returns registered read data to the port that owns the transaction.

Parameters:
D_WIDTH, 16, RAM word width
A_WIDTH, 12, RAM address width

Ports:
clock  in  1  system clock; all state changes on posedge
reset  in  1  synchronous, active-high reset
a_req_in  in  1  port A request; held stable until a_ack_out
a_write_in  in  1  1 = write, 0 = read
a_address_in  in  A_WIDTH  port A address
a_data_in  in  D_WIDTH  port A write data
a_ack_out  out  1  one-cycle completion pulse
a_data_out  out  D_WIDTH  port A last read data; holds otherwise
b_req_in, b_write_in, b_address_in, b_data_in, b_ack_out, b_data_out  same as port A, for port B
ram_data_in  in  D_WIDTH  from RAM data_out
ram_data_out  out  D_WIDTH  to RAM data_in
ram_address_out  out  A_WIDTH  to RAM address_in
ram_read_enable_out  out  1  to RAM read_enable_in
ram_write_enable_out  out  1  to RAM write_enable_in
busy_out  out  1  1 when state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE. Registers: owner, last_grant, latched write flag, latched address, latched data.
- Reset values:
  - state = IDLE, last_grant = B (so A wins the first tie), owner = A.
  - Both ack_out = 0, both data_out = 0.
  - All ram_* outputs = 0, busy_out = 0.
- IDLE: eligible port = req_in high AND its ack_out low. The just-acked port is excluded for that cycle, because its req is still high.
  - One eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - On a grant, latch that port's write/address/data, set owner and last_grant, go to ISSUE.
  - No eligible port: stay in IDLE.
- ISSUE (exactly one cycle):
  - ram_address_out / ram_data_out = latched values.
  - ram_write_enable_out = latched write; ram_read_enable_out = !latched write.
  - The RAM performs the access at the end of this cycle. Next state is CAPTURE.
- CAPTURE (one cycle):
  - All RAM enables = 0; ram_address_out and ram_data_out hold their latched values.
  - At posedge: set owner's ack_out = 1 for the next cycle. On a read, also load owner's data_out from ram_data_in. On a write, data_out is unchanged.
  - Next state is IDLE.
- Latency and throughput:
  - req first high in IDLE cycle N gives ISSUE in N+1, CAPTURE in N+2, ack_out and valid data_out in N+3.
  - Arbitration also runs in N+3, so there is one access per 3 cycles at best.
- ack_out is high for exactly one cycle per transaction. The requester must drop req (or present a new request) in the cycle after ack.
- Inputs sampled only at the IDLE grant edge. Changes to address/data/write after the grant do not affect the transaction in flight.
- RAM enables are forced to 0 whenever reset = 1, so no RAM write can occur in a reset cycle.
- Reset mid-transaction (ISSUE or CAPTURE): the transaction is aborted, no ack is issued, and all registers take their reset values at that edge.
- ram_read_enable_out and ram_write_enable_out are never both 1.
- Both enables are 0 outside ISSUE.
- Address/data widths pass through unchanged; no arithmetic.

Test Plan:
1. Reset, then A write 0x5F5F @0x001 (req at cycle 0) -> ram_write_enable_out=1 in cycle 1 only, a_ack_out=1 in cycle 3 only, a_data_out stays 0x0000, busy_out=1 in cycles 1-2.
2. After scenario 1, A read @0x001 -> ram_read_enable_out=1 in ISSUE, a_data_out=0x5F5F with a_ack_out in cycle 3, b_data_out stays 0x0000.
3. Preloaded RAM[0x200]=0x1234; A reads 0x200 and B reads 0x001 with both requests first high in the same cycle after reset -> A granted first (a_ack_out=1, a_data_out=0x1234), B granted in A's ack cycle, b_ack_out three cycles later with b_data_out=0x5F5F.
4. Both req held continuously for 4 transactions -> grants alternate A,B,A,B; acks spaced 3 cycles apart; no port acked twice in a row.
5. Reset asserted during ISSUE of a B write of 0xF5F5 @0x001 -> ram_write_enable_out=0 that cycle, no b_ack_out, RAM[0x001] still reads 0x5F5F afterwards.
6. A changes a_address_in from 0x001 to 0x000 during ISSUE of a read -> ram_address_out stays 0x001, returned data=0x5F5F.
